// File: rtl/shift_serializer_pkg.sv
// shift_serializer_pkg: shared state encodings and default word width for the serial datapath
package shift_serializer_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
endpackage

// File: rtl/shift_serializer_if.sv
// shift_serializer_if: load handshake and serial output bundle between a word source and the serializer
interface shift_serializer_if import shift_serializer_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;
  modport master (output load_valid, load_data, shift_en, input load_ready, ser_out, ser_valid, ser_last, busy);
  modport slave (input load_valid, load_data, shift_en, output load_ready, ser_out, ser_valid, ser_last, busy);
endinterface

// File: rtl/shift_serializer_bit_counter.sv
// bit_counter: modulo-WIDTH up-counter tracking the bit position within a word
module bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);
  logic [CW-1:0] r_cnt;
  // clear wins over increment so a reload restarts the word at bit 0
  always_ff @(posedge clk) begin
    if (rst || clr) r_cnt <= '0;
    else if (inc) r_cnt <= at_max ? '0 : r_cnt + 1'b1;
  end
  assign cnt    = r_cnt;
  assign at_max = r_cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/shift_serializer.sv
// shift_serializer: parallel-in serial-out transmitter with valid/ready load and back-to-back words
module shift_serializer import shift_serializer_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  shift_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    w_cnt;
  logic             w_at_max;
  logic             w_shifting;
  logic             w_accept;
  assign w_shifting = r_state == ST_SHIFT;
  assign bus.load_ready = !w_shifting || (w_at_max && bus.shift_en);
  assign w_accept = bus.load_valid && bus.load_ready;
  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_accept),
    .inc    (w_shifting && bus.shift_en),
    .cnt    (w_cnt),
    .at_max (w_at_max)
  );
  // accept loads a word, each strobe moves the next bit to the output end, last strobe idles and clears
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_shreg <= bus.load_data;
    end else if (w_shifting && bus.shift_en) begin
      r_state <= w_at_max ? ST_IDLE : ST_SHIFT;
      r_shreg <= w_at_max ? '0 : (MSB_FIRST ? r_shreg << 1 : r_shreg >> 1);
    end
  end
  assign bus.ser_valid = w_shifting;
  assign bus.busy      = w_shifting;
  assign bus.ser_out   = w_shifting && (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]);
  assign bus.ser_last  = w_shifting && (w_cnt == CW'(WIDTH - 1));
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: scoreboard bench driving MSB-first and LSB-first serializers with directed and random traffic
module tb_shift_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lv = 1'b0;
  logic [7:0] d = '0;
  logic se = 1'b0;
  int vec = 0;
  int err = 0;
  bit armed = 1'b0;
  bit qm[$];
  bit ql[$];
  always #5 clk = ~clk;
  shift_serializer_if #(.WIDTH(8)) if_m ();
  shift_serializer_if #(.WIDTH(8)) if_l ();
  assign if_m.load_valid = lv;
  assign if_m.load_data  = d;
  assign if_m.shift_en   = se;
  assign if_l.load_valid = lv;
  assign if_l.load_data  = d;
  assign if_l.shift_en   = se;
  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(if_m.slave));
  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(if_l.slave));

  task automatic check(input string n, input logic a, input logic e);
    vec++;
    if (a !== e) begin
      err++;
      $display("FAIL %s at %0t: got %b want %b", n, $time, a, e);
    end
  endtask

  // monitor compares outputs against the queued expected bits, then advances the model to the coming edge
  always @(negedge clk) begin
    bit rdy;
    rdy = qm.size() == 0 || (qm.size() == 1 && se);
    if (armed) begin
      check("m_valid", if_m.ser_valid, qm.size() != 0);
      check("m_busy",  if_m.busy,      qm.size() != 0);
      check("m_out",   if_m.ser_out,   qm.size() != 0 ? qm[0] : 1'b0);
      check("m_last",  if_m.ser_last,  qm.size() == 1);
      check("m_ready", if_m.load_ready, rdy);
      check("l_valid", if_l.ser_valid, ql.size() != 0);
      check("l_busy",  if_l.busy,      ql.size() != 0);
      check("l_out",   if_l.ser_out,   ql.size() != 0 ? ql[0] : 1'b0);
      check("l_last",  if_l.ser_last,  ql.size() == 1);
      check("l_ready", if_l.load_ready, rdy);
    end
    if (rst) begin
      qm.delete();
      ql.delete();
      armed = 1'b1;
    end else begin
      if (qm.size() != 0 && se) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (lv && rdy)
        for (int i = 0; i < 8; i++) begin
          qm.push_back(d[7-i]);
          ql.push_back(d[i]);
        end
    end
  end

  task automatic step(input logic v, input logic [7:0] x, input logic s, input logic r);
    lv = v;
    d = x;
    se = s;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    step(1, 8'hA5, 1, 0);
    repeat (7) step(0, 8'h00, 1, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(1, 8'hA5, 1, 0);
    repeat (6) step(0, 8'h00, 1, 0);
    step(1, 8'h3C, 1, 0);
    repeat (7) step(0, 8'h00, 1, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(1, 8'hF0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 8'h00, (i % 4) == 3, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(1, 8'h01, 1, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    step(1, 8'hFF, 1, 0);
    repeat (3) step(0, 8'h00, 1, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(1, 8'hA5, 1, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 1);
    step(1, 8'hFF, 1, 0);
    repeat (9) step(0, 8'h00, 1, 0);
    repeat (4) step(1, 8'h5A, 1, 1);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 150) == 0);
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) != 0, 8'($urandom), 1'b1, 1'b0);
    repeat (12) step(0, 8'h00, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
